spart_driver: RTL and testbench

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_driver_if.sv | 12 +
 rtl/spart_driver.sv | 150 +++++++++++++++
 tb/tb_spart_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/spart_driver_if.sv
// Control and status signals between the SPART driver and the SPART.
// The data bus is a tri-state net, so it stays a plain inout port on the driver.
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor, then polls status.
// Each received byte is read, counted and optionally echoed back.
module spart_driver #(
   parameter int ECHO_EN  = 1,
   parameter int POLL_GAP = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       br_cfg,
   spart_driver_if.master   bus,
   inout  wire  [7:0]       databus,
   output logic [7:0]       rx_byte,
   output logic [7:0]       rx_count,
   output logic             cfg_done
);

   typedef enum logic [2:0] {
      CFG_LO, CFG_HI, POLL_GAP_S, POLL_RDA, READ_RX, WAIT_TBR, WRITE_TX
   } state_t;

   localparam logic [4:0] GAP_N = 5'(POLL_GAP);

   state_t      state_q, state_d;
   logic [3:0]  gap_q, gap_d;
   logic [1:0]  cfg_reg_q, pend_q, pend_d;
   logic        cfg_done_q, cfg_done_d;
   logic [7:0]  rx_byte_q, rx_count_q;
   logic        iocs_q, iocs_d, iorw_q, iorw_d, drv_q, drv_d;
   logic [1:0]  ioaddr_q, ioaddr_d;
   logic [7:0]  dout_q, dout_d;
   logic [15:0] div_new, div_pend;
   logic        cfg_chg, gap_done;

   function automatic logic [15:0] divisor(input logic [1:0] sel);
      case (sel)
         2'b00:   divisor = 16'h28B1;
         2'b01:   divisor = 16'h1458;
         2'b10:   divisor = 16'h0A2C;
         default: divisor = 16'h0516;
      endcase
   endfunction

   assign cfg_chg  = (br_cfg != cfg_reg_q);
   assign gap_done = (({1'b0, gap_q} + 5'd1) >= GAP_N);
   assign div_new  = divisor(br_cfg);
   assign div_pend = divisor(pend_q);

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      cfg_done_d = cfg_done_q;
      case (state_q)
         // CFG_LO with iocs low is the post-reset entry: present its cycle first
         CFG_LO:     state_d = iocs_q ? CFG_HI : CFG_LO;
         CFG_HI: begin
            state_d    = POLL_GAP_S;
            cfg_done_d = 1'b1;
            gap_d      = 4'd0;
         end
         POLL_GAP_S: begin
            if (cfg_chg) begin
               cfg_done_d = 1'b0;
               state_d    = CFG_LO;
            end else if (gap_done) begin
               state_d = POLL_RDA;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         POLL_RDA: begin
            gap_d   = 4'd0;
            state_d = bus.rda ? READ_RX : POLL_GAP_S;
         end
         READ_RX: begin
            gap_d   = 4'd0;
            state_d = (ECHO_EN != 0) ? WAIT_TBR : POLL_GAP_S;
         end
         WAIT_TBR: begin
            if (cfg_chg) begin
               cfg_done_d = 1'b0;
               state_d    = CFG_LO;
            end else if (bus.tbr) begin
               state_d = WRITE_TX;
            end
         end
         WRITE_TX: begin
            gap_d   = 4'd0;
            state_d = POLL_GAP_S;
         end
         default:    state_d = CFG_LO;
      endcase

      // Outputs are registered from the state being entered
      iocs_d   = 1'b0;
      iorw_d   = 1'b1;
      ioaddr_d = 2'b01;
      drv_d    = 1'b0;
      dout_d   = dout_q;
      pend_d   = (state_d == CFG_LO) ? br_cfg : pend_q;
      case (state_d)
         CFG_LO:   begin iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b10; drv_d = 1'b1; dout_d = div_new[7:0]; end
         CFG_HI:   begin iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b11; drv_d = 1'b1; dout_d = div_pend[15:8]; end
         POLL_RDA: begin iocs_d = 1'b1; iorw_d = 1'b1; ioaddr_d = 2'b01; end
         READ_RX:  begin iocs_d = 1'b1; iorw_d = 1'b1; ioaddr_d = 2'b00; end
         WRITE_TX: begin iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b00; drv_d = 1'b1; dout_d = rx_byte_q; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= CFG_LO;
         gap_q      <= 4'd0;
         cfg_reg_q  <= 2'b00;
         pend_q     <= 2'b00;
         cfg_done_q <= 1'b0;
         rx_byte_q  <= 8'h00;
         rx_count_q <= 8'h00;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= 2'b01;
         drv_q      <= 1'b0;
         dout_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         pend_q     <= pend_d;
         cfg_done_q <= cfg_done_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         drv_q      <= drv_d;
         dout_q     <= dout_d;
         if (state_q == CFG_HI) cfg_reg_q <= pend_q;
         if (state_q == READ_RX) begin
            rx_byte_q  <= databus;
            rx_count_q <= rx_count_q + 8'd1;
         end
      end
   end

   assign databus    = drv_q ? dout_q : 8'hzz;
   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = ioaddr_q;
   assign rx_byte    = rx_byte_q;
   assign rx_count   = rx_count_q;
   assign cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a minimal SPART responder on the bus.
module tb_spart_driver;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] br_cfg = 2'b01;
   wire  [7:0] databus;
   logic [7:0] rx_byte, rx_count;
   logic       cfg_done;
   logic [7:0] spart_rx = 8'h00;
   logic       spart_oe;
   int         total = 0;
   int         bad = 0;

   spart_driver_if bus ();

   spart_driver #(.ECHO_EN(1), .POLL_GAP(2)) dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus), .databus(databus),
      .rx_byte(rx_byte), .rx_count(rx_count), .cfg_done(cfg_done)
   );

   always #5 clk = ~clk;

   // SPART side drives received data only during a buffer read
   assign spart_oe = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);
   assign databus  = spart_oe ? spart_rx : 8'hzz;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input logic [1:0] a, input logic rw, input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         tick();
         if (bus.iocs && (bus.iorw == rw) && (bus.ioaddr == a)) ok = 1'b1;
      end
   endtask

   task automatic chk_wr(input string tag, input logic [1:0] a, input logic [7:0] d);
      chk({tag, "_cs"}, 16'(bus.iocs), 16'd1);
      chk({tag, "_rw"}, 16'(bus.iorw), 16'd0);
      chk({tag, "_ad"}, 16'(bus.ioaddr), 16'(a));
      chk({tag, "_db"}, 16'(databus), 16'(d));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok, seen;
      bus.rda = 1'b0;
      bus.tbr = 1'b0;
      // Reset values
      tick(); tick();
      chk("rst_cs", 16'(bus.iocs), 16'd0);
      chk("rst_rw", 16'(bus.iorw), 16'd1);
      chk("rst_ad", 16'(bus.ioaddr), 16'd1);
      chk("rst_cnt", 16'(rx_count), 16'h00);
      chk("rst_byte", 16'(rx_byte), 16'h00);
      chk("rst_done", 16'(cfg_done), 16'd0);
      rst = 1'b1;

      // Divisor programming for 9600
      tick(); chk_wr("cfg_lo", 2'b10, 8'h58); chk("cfg_lo_done", 16'(cfg_done), 16'd0);
      tick(); chk_wr("cfg_hi", 2'b11, 8'h14); chk("cfg_hi_done", 16'(cfg_done), 16'd0);
      tick(); chk("cfg_done", 16'(cfg_done), 16'd1); chk("gap_cs", 16'(bus.iocs), 16'd0);

      // Receive 0xA5, echo held back by tbr=0 for 20 cycles
      spart_rx = 8'hA5; bus.rda = 1'b1;
      wait_acc(2'b00, 1'b1, 20, ok); chk("rd_seen", 16'(ok), 16'd1);
      bus.rda = 1'b0;
      tick();
      chk("rd_byte", 16'(rx_byte), 16'h00A5);
      chk("rd_cnt", 16'(rx_count), 16'd1);
      seen = bus.iocs;
      for (int i = 0; i < 19; i++) begin tick(); seen = seen | bus.iocs; end
      chk("tbr_idle", 16'(seen), 16'd0);
      bus.tbr = 1'b1;
      tick(); chk_wr("echo", 2'b00, 8'hA5);
      bus.tbr = 1'b0;

      // 255 more bytes wrap the counter
      bus.rda = 1'b1; bus.tbr = 1'b1; seen = 1'b0;
      for (int i = 0; i < 255; i++) begin
         spart_rx = 8'(i);
         wait_acc(2'b00, 1'b1, 20, ok);
         if (!ok) seen = 1'b1;
         if (i == 127) chk("cnt_mid", 16'(rx_count), 16'd128);
      end
      chk("wrap_reads", 16'(seen), 16'd0);
      bus.rda = 1'b0; bus.tbr = 1'b0;
      tick();
      chk("wrap_cnt", 16'(rx_count), 16'h00);
      chk("wrap_byte", 16'(rx_byte), 16'h00FE);

      // Reconfiguration from WAIT_TBR drops the pending echo
      br_cfg = 2'b00;
      tick(); chk_wr("rc0_lo", 2'b10, 8'hB1); chk("rc0_done_lo", 16'(cfg_done), 16'd0);
      tick(); chk_wr("rc0_hi", 2'b11, 8'h28);
      tick(); chk("rc0_done", 16'(cfg_done), 16'd1);
      bus.tbr = 1'b1;
      wait_acc(2'b00, 1'b0, 15, ok); chk("echo_dropped", 16'(ok), 16'd0);
      bus.tbr = 1'b0;

      // Idle reconfiguration 01 -> 11
      br_cfg = 2'b01;
      wait_acc(2'b10, 1'b0, 20, ok); chk("rc1_seen", 16'(ok), 16'd1);
      tick(); tick();
      chk("rc1_done", 16'(cfg_done), 16'd1);
      br_cfg = 2'b11;
      wait_acc(2'b10, 1'b0, 20, ok); chk("rc3_seen", 16'(ok), 16'd1);
      chk_wr("rc3_lo", 2'b10, 8'h16); chk("rc3_done_lo", 16'(cfg_done), 16'd0);
      tick(); chk_wr("rc3_hi", 2'b11, 8'h05);
      tick(); chk("rc3_done", 16'(cfg_done), 16'd1);

      // Asynchronous reset during an echo write
      spart_rx = 8'h3C; bus.rda = 1'b1; bus.tbr = 1'b1;
      wait_acc(2'b00, 1'b0, 30, ok); chk("wr_seen", 16'(ok), 16'd1);
      chk("wr_db", 16'(databus), 16'h003C);
      rst = 1'b0;
      #1;
      chk("arst_cs", 16'(bus.iocs), 16'd0);
      chk("arst_db", 16'(databus === 8'h3C), 16'd0);
      chk("arst_cnt", 16'(rx_count), 16'h00);
      chk("arst_done", 16'(cfg_done), 16'd0);
      bus.rda = 1'b0; bus.tbr = 1'b0;
      tick();
      rst = 1'b1;
      tick(); chk_wr("rel_lo", 2'b10, 8'h16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
